// File: rtl/pf_vf_mux_pkg.sv
// Routing-table entry shared by the PF/VF MUX and the FLR port-reset sequencer.
package pf_vf_mux_pkg;
   localparam int RT_PF_WIDTH   = 3;
   localparam int RT_VF_WIDTH   = 11;
   localparam int RT_PORT_WIDTH = 8;

   typedef struct packed {
      logic [RT_PF_WIDTH-1:0]   pf;
      logic [RT_VF_WIDTH-1:0]   vf;
      logic                     vf_active;
      logic [RT_PORT_WIDTH-1:0] pfvf_port;
   } t_pfvf_rtable_entry;
endpackage

// File: rtl/pf_vf_flr_port_rst.sv
// FLR sequencer: maps an FLR to its MUX ports via the routing table, drains, resets, releases, acks.
// Latency accept->ack 4+RST_HOLD_CYCLES (idle ports) or 2 (miss); one FLR in flight, ready low while busy, ack never stalls.
module pf_vf_flr_port_rst #(
   parameter int NUM_PORT           = 4,
   parameter int NUM_RTABLE_ENTRIES = 4,
   parameter int PF_WIDTH           = 3,
   parameter int VF_WIDTH           = 11,
   parameter pf_vf_mux_pkg::t_pfvf_rtable_entry [NUM_RTABLE_ENTRIES-1:0] RTABLE = '0,
   parameter int RST_HOLD_CYCLES    = 64,
   parameter int DRAIN_TIMEOUT      = 1024
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                flr_req_valid,
   output logic                flr_req_ready,
   input  logic [PF_WIDTH-1:0] flr_req_pf,
   input  logic [VF_WIDTH-1:0] flr_req_vf,
   input  logic                flr_req_vf_active,
   input  logic [NUM_PORT-1:0] port_idle,
   output logic [NUM_PORT-1:0] port_rst_n,
   output logic                flr_ack_valid,
   output logic [PF_WIDTH-1:0] flr_ack_pf,
   output logic [VF_WIDTH-1:0] flr_ack_vf,
   output logic                flr_ack_vf_active,
   output logic                flr_ack_miss,
   output logic                flr_ack_timeout
);
   localparam int CNT_SPAN = (RST_HOLD_CYCLES > DRAIN_TIMEOUT) ? RST_HOLD_CYCLES : DRAIN_TIMEOUT;
   localparam int CNT_W    = $clog2(CNT_SPAN) + 1;
   localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(RST_HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_TIMEOUT - 1);

   typedef enum logic [2:0] {
      ST_IDLE, ST_LOOKUP, ST_DRAIN, ST_ASSERT, ST_RELEASE, ST_ACK
   } state_t;

   state_t              state;
   logic [PF_WIDTH-1:0] pf_q;
   logic [VF_WIDTH-1:0] vf_q;
   logic                vf_active_q;
   logic [NUM_PORT-1:0] mask;
   logic [NUM_PORT-1:0] lookup_mask;
   logic [CNT_W-1:0]    cnt;
   logic                timeout_q;
   logic                drain_done;

   // Same table the MUX routes with, so reset scope always equals routing scope.
   always_comb begin
      lookup_mask = '0;
      for (int p = 0; p < NUM_PORT; p++) begin
         for (int e = 0; e < NUM_RTABLE_ENTRIES; e++) begin
            if ((PF_WIDTH'(RTABLE[e].pf) == pf_q) &&
                (!vf_active_q || (RTABLE[e].vf_active && (VF_WIDTH'(RTABLE[e].vf) == vf_q))) &&
                (int'(RTABLE[e].pfvf_port) == p)) begin
               lookup_mask[p] = 1'b1;
            end
         end
      end
   end

   assign drain_done = ((port_idle & mask) == mask);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state             <= ST_IDLE;
         flr_req_ready     <= 1'b0;
         port_rst_n        <= '0;
         flr_ack_valid     <= 1'b0;
         flr_ack_pf        <= '0;
         flr_ack_vf        <= '0;
         flr_ack_vf_active <= 1'b0;
         flr_ack_miss      <= 1'b0;
         flr_ack_timeout   <= 1'b0;
         pf_q              <= '0;
         vf_q              <= '0;
         vf_active_q       <= 1'b0;
         mask              <= '0;
         cnt               <= '0;
         timeout_q         <= 1'b0;
      end else begin
         flr_ack_valid     <= 1'b0;
         flr_ack_pf        <= '0;
         flr_ack_vf        <= '0;
         flr_ack_vf_active <= 1'b0;
         flr_ack_miss      <= 1'b0;
         flr_ack_timeout   <= 1'b0;
         case (state)
            ST_IDLE: begin
               port_rst_n    <= '1;
               flr_req_ready <= 1'b1;
               if (flr_req_valid && flr_req_ready) begin
                  pf_q          <= flr_req_pf;
                  vf_q          <= flr_req_vf;
                  vf_active_q   <= flr_req_vf_active;
                  flr_req_ready <= 1'b0;
                  state         <= ST_LOOKUP;
               end
            end
            ST_LOOKUP: begin
               mask <= lookup_mask;
               cnt  <= '0;
               if (lookup_mask == '0) begin
                  flr_ack_valid     <= 1'b1;
                  flr_ack_pf        <= pf_q;
                  flr_ack_vf        <= vf_q;
                  flr_ack_vf_active <= vf_active_q;
                  flr_ack_miss      <= 1'b1;
                  state             <= ST_ACK;
               end else begin
                  state <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               // Idle wins over timeout when both happen on the last allowed cycle.
               if (drain_done || (cnt == DRAIN_LAST)) begin
                  timeout_q  <= !drain_done;
                  port_rst_n <= ~mask;
                  cnt        <= '0;
                  state      <= ST_ASSERT;
               end else if (cnt != '1) begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_ASSERT: begin
               if (cnt == HOLD_LAST) begin
                  port_rst_n <= '1;
                  state      <= ST_RELEASE;
               end else if (cnt != '1) begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_RELEASE: begin
               flr_ack_valid     <= 1'b1;
               flr_ack_pf        <= pf_q;
               flr_ack_vf        <= vf_q;
               flr_ack_vf_active <= vf_active_q;
               flr_ack_timeout   <= timeout_q;
               state             <= ST_ACK;
            end
            ST_ACK: begin
               flr_req_ready <= 1'b1;
               mask          <= '0;
               timeout_q     <= 1'b0;
               state         <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule
